// File: rtl/dec_sel_arbiter_8_if.sv
// Bus between eight requesters and the shared 3-to-8 decoder arbiter.
// Requesters (master) drive req/done; the arbiter (slave) drives the decoder controls.
interface dec_sel_arbiter_8_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       sel_en;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  sel_en,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output sel_en,
        output busy,
        output timeout
    );
endinterface

// File: rtl/dec_sel_arbiter_8.sv
// Round-robin arbiter driving a shared 3-to-8 decoder's address and enable from flops,
// holding each grant until release or timeout and inserting a one-cycle dead gap.
module dec_sel_arbiter_8 #(
    parameter int unsigned HOLD_W   = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                 clk,
    input logic                 rst,
    dec_sel_arbiter_8_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e            state;
    logic [2:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        winner;
    logic              owner_release;
    logic              timeout_hit;

    // Scan from the far end so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        winner = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[ptr + 3'(k)]) begin
                winner = ptr + 3'(k);
            end
        end
    end

    assign owner_release = bus.done || !bus.req[bus.sel];
    assign timeout_hit   = (MAX_HOLD != 0) && (hold_cnt == HoldLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            ptr         <= 3'd0;
            hold_cnt    <= '0;
            bus.sel     <= 3'd0;
            bus.sel_en  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            unique case (state)
                StIdle, StGap: begin
                    if (|bus.req) begin
                        bus.sel    <= winner;
                        bus.sel_en <= 1'b1;
                        bus.busy   <= 1'b1;
                        hold_cnt   <= '0;
                        state      <= StGrant;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= StIdle;
                    end
                end
                StGrant: begin
                    if (owner_release || timeout_hit) begin
                        bus.sel_en  <= 1'b0;
                        ptr         <= bus.sel + 3'd1;
                        // A coincident owner release takes precedence over the timeout flag.
                        bus.timeout <= timeout_hit && !owner_release;
                        state       <= StGap;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    bus.sel_en <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_sel_arbiter_8.sv
// Bench for dec_sel_arbiter_8: directed scenarios plus random traffic against a
// grant-age reference model.
module tb_dec_sel_arbiter_8;

    localparam int unsigned TbMaxHold = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dec_sel_arbiter_8_if bus ();

    dec_sel_arbiter_8 #(
        .HOLD_W   (8),
        .MAX_HOLD (TbMaxHold)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a grant is described by its owner and how many enabled cycles it has had.
    int m_sel, m_ptr, m_age;
    bit m_en, m_gap, m_to;

    int grants[$];
    int n_timeouts;
    bit prev_en;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_ptr = 0; m_age = 0;
        m_en = 0; m_gap = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        bit by_owner, by_time;
        int w;
        m_to = 0;
        if (m_en) begin
            by_owner = d || !r[m_sel];
            by_time  = (TbMaxHold != 0) && (m_age == TbMaxHold);
            if (by_owner || by_time) begin
                m_en  = 0;
                m_gap = 1;
                m_ptr = (m_sel + 1) % 8;
                m_to  = !by_owner;
            end else begin
                m_age++;
            end
        end else begin
            m_gap = 0;
            w = pick(m_ptr, r);
            if (w >= 0) begin
                m_sel = w;
                m_en  = 1;
                m_age = 1;
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".sel"},     {5'd0, bus.sel}, 8'(m_sel));
        check({ctx, ".sel_en"},  {7'd0, bus.sel_en}, {7'd0, m_en});
        check({ctx, ".busy"},    {7'd0, bus.busy}, {7'd0, m_en || m_gap});
        check({ctx, ".timeout"}, {7'd0, bus.timeout}, {7'd0, m_to});
    endtask

    task automatic cycle(input logic [7:0] r, input logic d, input string ctx);
        bus.req  = r;
        bus.done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        check_outputs(ctx);
        if (bus.sel_en && !prev_en) grants.push_back(int'(bus.sel));
        if (bus.timeout) n_timeouts++;
        prev_en = bus.sel_en;
    endtask

    task automatic do_reset();
        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst      = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        rst        = 1'b0;
        prev_en    = 1'b0;
        n_timeouts = 0;
        grants.delete();
    endtask

    task automatic check_grants(input string tag, input int exp[$]);
        check({tag, ".count"}, 8'(grants.size()), 8'(exp.size()));
        for (int i = 0; i < exp.size() && i < grants.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), 8'(grants[i]), 8'(exp[i]));
        end
    endtask

    initial begin
        logic [7:0] r;
        logic       d;

        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst      = 1'b1;
        #1;
        check("async_reset.sel_en", {7'd0, bus.sel_en}, 8'h00);

        // No requests: everything stays quiet.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(8'h00, 1'b0, "idle");

        // Two requesters, done on the third grant cycle.
        do_reset();
        cycle(8'h24, 1'b0, "two");
        cycle(8'h24, 1'b0, "two");
        cycle(8'h24, 1'b0, "two");
        cycle(8'h24, 1'b1, "two");
        check("two.gap_sel_en", {7'd0, bus.sel_en}, 8'h00);
        cycle(8'h24, 1'b0, "two");
        cycle(8'h24, 1'b0, "two");
        cycle(8'h24, 1'b0, "two");
        cycle(8'h24, 1'b1, "two");
        cycle(8'h24, 1'b0, "two");
        check_grants("two.order", '{2, 5, 2});

        // All requesting, done every second grant cycle: strict rotation with wrap.
        do_reset();
        for (int g = 0; g < 9; g++) begin
            cycle(8'hFF, 1'b0, "all");
            cycle(8'hFF, 1'b0, "all");
            cycle(8'hFF, 1'b1, "all");
        end
        check_grants("all.order", '{0, 1, 2, 3, 4, 5, 6, 7, 0});

        // Single persistent requester never releasing: timeout after MAX_HOLD cycles.
        do_reset();
        for (int i = 0; i < 11; i++) cycle(8'h08, 1'b0, "hold");
        check_grants("hold.order", '{3, 3, 3});
        check("hold.timeouts", 8'(n_timeouts), 8'd2);

        // Owner drops its request mid-grant, then done coincides with the timeout.
        do_reset();
        cycle(8'h40, 1'b0, "drop");
        cycle(8'h42, 1'b0, "drop");
        cycle(8'h02, 1'b0, "drop");
        check("drop.released", {7'd0, bus.sel_en}, 8'h00);
        cycle(8'h02, 1'b0, "drop");
        cycle(8'h02, 1'b0, "drop");
        cycle(8'h02, 1'b0, "drop");
        cycle(8'h02, 1'b0, "drop");
        cycle(8'h02, 1'b1, "drop");
        check("drop.coincide_timeout", {7'd0, bus.timeout}, 8'h00);
        check("drop.coincide_sel_en", {7'd0, bus.sel_en}, 8'h00);
        check_grants("drop.order", '{6, 1});

        // Asynchronous reset in the middle of a grant to requester 4.
        do_reset();
        cycle(8'h10, 1'b0, "arst");
        check("arst.pre_sel", {5'd0, bus.sel}, 8'h04);
        #2;
        rst = 1'b1;
        #1;
        check("arst.sel_en", {7'd0, bus.sel_en}, 8'h00);
        check("arst.busy", {7'd0, bus.busy}, 8'h00);
        check("arst.sel", {5'd0, bus.sel}, 8'h00);
        do_reset();
        cycle(8'h10, 1'b0, "arst");
        check("arst.regrant_sel", {5'd0, bus.sel}, 8'h04);
        check("arst.regrant_en", {7'd0, bus.sel_en}, 8'h01);

        // Random traffic with requests that persist for a while.
        do_reset();
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 4) == 0) r = 8'h00;
            end
            d = ($urandom_range(0, 4) == 0);
            cycle(r, d, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
